half_adder_bist: RTL
====================

HALF_ADDER_BIST -- requirements
Module: half_adder_bist

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: DWELL, default 4, settle cycles per vector before sampling; legal range 1..255.
REQ-003 Port: CLK  input  1  rising-edge clock.
REQ-004 Port: RESET  input  1  asynchronous, active-high reset.
REQ-005 Port: START  input  1  run request, sampled on CLK.
REQ-006 Port: A  output  1  stimulus bit A to the unit under test.
REQ-007 Port: B  output  1  stimulus bit B to the unit under test.
REQ-008 Port: S  input  1  sum response from the unit under test.
REQ-009 Port: C  input  1  carry response from the unit under test.
REQ-010 Port: BUSY  output  1  high while a run is in progress.
REQ-011 Port: DONE  output  1  high while the run result is valid.
REQ-012 Port: PASS  output  1  high when DONE is high and ERR_COUNT is 0.
REQ-013 Port: ERR_COUNT  output  3  number of failing vectors in the last run, range 0..4.
REQ-014 Port: FAIL_VEC  output  2  {A,B} of the first failing vector.
REQ-015 Port: FAIL_VALID  output  1  high when FAIL_VEC holds a captured failure.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, SAMPLE and REPORT.
REQ-017 IDLE: A=B=0, BUSY=0; START=1 at a rising edge -> SETTLE on that edge, with these actions:
  - vector index cleared to 0;
  - ERR_COUNT, FAIL_VEC, FAIL_VALID, DONE and PASS cleared.
REQ-018 Vector order SHALL be {A,B} = 00, 01, 10, 11; A and B SHALL be registered outputs equal to the current index in SETTLE and SAMPLE.
REQ-019 SETTLE SHALL last exactly DWELL cycles, counted by an 8-bit dwell counter, then go to SAMPLE.
REQ-020 SAMPLE SHALL last one cycle. It SHALL compare S against A^B and C against A&B. A mismatch on either bit SHALL:
  - increment ERR_COUNT;
  - if FAIL_VALID=0, load FAIL_VEC with {A,B} and set FAIL_VALID.
REQ-021 SAMPLE with index<3 -> SETTLE with index+1 and dwell counter cleared; SAMPLE with index=3 -> REPORT.
REQ-022 BUSY SHALL be 1 in SETTLE and SAMPLE, and 0 in IDLE and REPORT.
REQ-023 REPORT: A=B=0, DONE=1, PASS=(ERR_COUNT==0); results SHALL hold until the next run starts.
REQ-024 START=1 in REPORT SHALL restart exactly as from IDLE (REQ-017); START SHALL be ignored while BUSY=1.
REQ-025 Latency: with START sampled at edge 0, SETTLE SHALL begin at edge 1 and REPORT at edge 1+4*(DWELL+1); DWELL=4 gives edge 21.
REQ-026 ERR_COUNT SHALL NOT wrap: its maximum is 4, and 3 bits are sufficient.
REQ-027 S and C SHALL be sampled only in SAMPLE; their values in other states SHALL have no effect.

Reset
REQ-028 RESET=1 SHALL force the following immediately, without waiting for a clock edge, including mid-run:
  - state to IDLE;
  - A, B, BUSY, DONE, PASS, FAIL_VALID to 0;
  - ERR_COUNT, FAIL_VEC, index and dwell counter to 0.
REQ-029 After RESET is released, the block SHALL remain in IDLE until START=1 is sampled.

Verification
REQ-030 Correct half-adder model, DWELL=4, START pulse -> at edge 21: DONE=1, PASS=1, ERR_COUNT=0, FAIL_VALID=0, and A/B observed to step 00,01,10,11.
REQ-031 Carry stuck at 0 -> ERR_COUNT=1, FAIL_VEC=11, FAIL_VALID=1, PASS=0.
REQ-032 S and C swapped -> ERR_COUNT=3, FAIL_VEC=01, PASS=0.
REQ-033 RESET asserted during vector 10 -> all outputs 0 with no clock edge; next START runs a full pass from vector 00.
REQ-034 START held high throughout a run -> no restart while BUSY; the block restarts immediately at the first edge in REPORT (DONE high for one cycle), and a second correct run yields PASS=1.
REQ-035 DWELL=1 -> REPORT at edge 9, and every vector is held exactly 2 cycles.

Source files
------------

// File: rtl/half_adder_bist_if.sv
// Signal bundle between the half-adder BIST controller, the adder under test
// and whoever requests runs and reads back the results.
interface half_adder_bist_if;
    logic       START;
    logic       A;
    logic       B;
    logic       S;
    logic       C;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [2:0] ERR_COUNT;
    logic [1:0] FAIL_VEC;
    logic       FAIL_VALID;

    // master is the BIST controller; slave is the adder plus run requester
    modport master (
        input  START, S, C,
        output A, B, BUSY, DONE, PASS, ERR_COUNT, FAIL_VEC, FAIL_VALID
    );

    modport slave (
        output START, S, C,
        input  A, B, BUSY, DONE, PASS, ERR_COUNT, FAIL_VEC, FAIL_VALID
    );
endinterface

// File: rtl/half_adder_bist.sv
// Built-in self test for a half adder: walks {A,B} through 00..11, lets each
// vector settle for DWELL cycles, samples S/C once and reports error statistics.
module half_adder_bist #(
    parameter int unsigned DWELL = 4
) (
    input logic               CLK,
    input logic               RESET,
    half_adder_bist_if.master bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    // Settle ends when the counter reaches DWELL-1, giving exactly DWELL cycles
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    logic [1:0] state;
    logic [1:0] vec_idx;
    logic [7:0] dwell_cnt;
    logic       a_q;
    logic       b_q;
    logic [2:0] err_count;
    logic [1:0] fail_vec;
    logic       fail_valid;
    logic       mismatch;

    assign mismatch = (bus.S != (a_q ^ b_q)) || (bus.C != (a_q & b_q));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            vec_idx    <= 2'd0;
            dwell_cnt  <= 8'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            err_count  <= 3'd0;
            fail_vec   <= 2'd0;
            fail_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_REPORT: begin
                    if (bus.START) begin
                        state      <= ST_SETTLE;
                        vec_idx    <= 2'd0;
                        dwell_cnt  <= 8'd0;
                        a_q        <= 1'b0;
                        b_q        <= 1'b0;
                        err_count  <= 3'd0;
                        fail_vec   <= 2'd0;
                        fail_valid <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != 3'd4) begin
                            err_count <= err_count + 3'd1;
                        end
                        if (!fail_valid) begin
                            fail_vec   <= {a_q, b_q};
                            fail_valid <= 1'b1;
                        end
                    end
                    if (vec_idx == 2'd3) begin
                        state <= ST_REPORT;
                        a_q   <= 1'b0;
                        b_q   <= 1'b0;
                    end else begin
                        state        <= ST_SETTLE;
                        vec_idx      <= vec_idx + 2'd1;
                        dwell_cnt    <= 8'd0;
                        {a_q, b_q}   <= vec_idx + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status flags decode straight from the state so reset clears them at once
    assign bus.A          = a_q;
    assign bus.B          = b_q;
    assign bus.BUSY       = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign bus.DONE       = (state == ST_REPORT);
    assign bus.PASS       = (state == ST_REPORT) && (err_count == 3'd0);
    assign bus.ERR_COUNT  = err_count;
    assign bus.FAIL_VEC   = fail_vec;
    assign bus.FAIL_VALID = fail_valid;

endmodule
